// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: per channel a 2-flop synchroniser, a
// symmetric debounce counter and a hold-timer FSM producing press/release/long/repeat pulses.
module debounce_multi #(
  parameter int N      = 4,
  parameter int CNT_W  = 4,
  parameter int BOUND  = 4,
  parameter int HOLD_W = 8,
  parameter int LONG   = 20,
  parameter int REPEAT = 8
) (
  input  logic         clk,
  input  logic         r,
  input  logic [N-1:0] btn_n,
  output logic [N-1:0] held,
  output logic [N-1:0] press,
  output logic [N-1:0] release_p,
  output logic [N-1:0] long_press,
  output logic [N-1:0] repeat_p,
  output logic         any_press
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_REPEATING = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_TC  = CNT_W'(BOUND - 1);
  localparam logic [HOLD_W-1:0] LONG_TC = HOLD_W'(LONG - 1);
  localparam logic [HOLD_W-1:0] REP_TC  = HOLD_W'((REPEAT == 0) ? 0 : REPEAT - 1);

  logic [N-1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N-1:0]      held_q, held_d;
  logic [N-1:0]      press_q, press_d, release_q, release_d;
  logic [N-1:0]      long_q, long_d, rep_q, rep_d;
  logic              any_press_q, any_press_d;
  logic [N-1:0]      smp_s;
  logic [CNT_W-1:0]  cnt_q  [N];
  logic [CNT_W-1:0]  cnt_d  [N];
  logic [HOLD_W-1:0] hcnt_q [N];
  logic [HOLD_W-1:0] hcnt_d [N];
  state_e            state_q [N];
  state_e            state_d [N];

  assign smp_s = ~sync2_q;

  // Debounce and hold-timer next state for every channel
  always_comb begin
    sync1_d   = btn_n;
    sync2_d   = sync1_q;
    held_d    = held_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    rep_d     = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]   = cnt_q[i];
      hcnt_d[i]  = hcnt_q[i];
      state_d[i] = state_q[i];
      if (smp_s[i] == held_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        held_d[i]    = smp_s[i];
        cnt_d[i]     = '0;
        press_d[i]   = smp_s[i];
        release_d[i] = ~smp_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      // A release flip pre-empts any terminal count on the same edge
      if (release_d[i]) begin
        state_d[i] = ST_IDLE;
        hcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (press_d[i]) begin
              state_d[i] = ST_PRESSED;
              hcnt_d[i]  = '0;
            end else begin
              hcnt_d[i] = hcnt_q[i];
            end
          end
          ST_PRESSED: begin
            if (hcnt_q[i] == LONG_TC) begin
              long_d[i]  = 1'b1;
              hcnt_d[i]  = '0;
              state_d[i] = ST_REPEATING;
            end else begin
              hcnt_d[i] = hcnt_q[i] + 1'b1;
            end
          end
          ST_REPEATING: begin
            if (REPEAT != 0) begin
              if (hcnt_q[i] == REP_TC) begin
                rep_d[i]  = 1'b1;
                hcnt_d[i] = '0;
              end else begin
                hcnt_d[i] = hcnt_q[i] + 1'b1;
              end
            end else begin
              hcnt_d[i] = hcnt_q[i];
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            hcnt_d[i]  = '0;
          end
        endcase
      end
    end
    any_press_d = |press_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      held_q      <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      rep_q       <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]   <= '0;
        hcnt_q[i]  <= '0;
        state_q[i] <= ST_IDLE;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      held_q      <= held_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      rep_q       <= rep_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]   <= cnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign held       = held_q;
  assign press      = press_q;
  assign release_p  = release_q;
  assign long_press = long_q;
  assign repeat_p   = rep_q;
  assign any_press  = any_press_q;

endmodule
